// File: rtl/case_pkg.sv
// -----------------------------------------------------------------------------
// case_pkg
// Shared definitions for the streaming ASCII case converter:
//   - mode_t       : conversion mode carried with each message
//   - ASCII_*      : inclusive bounds of the upper/lower letter classes
//   - CASE_BIT     : bit that differs between an upper and lower letter
//   - CASE_MASK    : byte mask with only CASE_BIT set
//   - state_t      : message framing FSM state (IDLE / IN_MSG)
// -----------------------------------------------------------------------------
package case_pkg;

   typedef enum logic [1:0] {
      MODE_PASS   = 2'd0,
      MODE_UPPER  = 2'd1,
      MODE_LOWER  = 2'd2,
      MODE_TOGGLE = 2'd3
   } mode_t;

   localparam logic [7:0] ASCII_UPPER_LO = 8'h41;  // 'A'
   localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;  // 'Z'
   localparam logic [7:0] ASCII_LOWER_LO = 8'h61;  // 'a'
   localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;  // 'z'

   localparam int         CASE_BIT  = 5;
   localparam logic [7:0] CASE_MASK = 8'h01 << CASE_BIT;

   // Framing FSM: either waiting for the first beat of a message or inside one.
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE   = 1'b0;
   localparam state_t ST_IN_MSG = 1'b1;

endpackage

// File: rtl/case_convert_lane.sv
// -----------------------------------------------------------------------------
// case_convert_lane
// Purely combinational single-byte case converter.
// Ports:
//   char_in  in  8  input character
//   mode     in  2  conversion mode (mode_t encoding)
//   char_out out 8  converted character
//   changed  out 1  high when char_out differs from char_in
// Only ASCII letters are touched; every other byte, including 0x80..0xFF,
// passes through unchanged.
// -----------------------------------------------------------------------------
module case_convert_lane
   import case_pkg::*;
(
   input  logic [7:0] char_in,
   input  logic [1:0] mode,
   output logic [7:0] char_out,
   output logic       changed
);

   logic is_upper;
   logic is_lower;
   logic flip;

   always_comb begin
      is_upper = (char_in >= ASCII_UPPER_LO) && (char_in <= ASCII_UPPER_HI);
      is_lower = (char_in >= ASCII_LOWER_LO) && (char_in <= ASCII_LOWER_HI);

      // NOTE: every always_comb output gets a default before any branch, so no
      // path through the block can leave it unassigned and infer a latch.
      flip = 1'b0;
      case (mode_t'(mode))
         MODE_UPPER:  flip = is_lower;
         MODE_LOWER:  flip = is_upper;
         MODE_TOGGLE: flip = is_lower || is_upper;
         default:     flip = 1'b0;
      endcase

      changed  = flip;
      char_out = flip ? (char_in ^ CASE_MASK) : char_in;
   end

endmodule

// File: rtl/case_convert_stream.sv
// -----------------------------------------------------------------------------
// case_convert_stream
// Streaming ASCII case converter, LANES bytes per beat, valid/ready in and out,
// messages framed by a last flag. The mode is latched on the first beat of a
// message and held for the rest of it. Converted beats leave one cycle after
// acceptance; the final beat carries the saturating count of changed
// characters for the whole message.
// Parameters:
//   LANES    bytes per beat (1..16), lane 0 in bits [7:0] is the first char
//   COUNT_W  width of the saturating changed-character counter
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mode      in  2   0=PASS 1=UPPER 2=LOWER 3=TOGGLE, sampled on first beat
//   s_valid/s_ready   input handshake (s_ready is registered)
//   s_data    in      8*LANES input characters
//   s_last    in      final beat of message
//   m_valid/m_ready   output handshake (m_valid is registered)
//   m_data    out     8*LANES converted characters
//   m_last    out     final beat of message
//   m_count   out     message changed-character total, non-zero only on the
//                     last beat while m_valid
// Buffering is an output register plus a one-entry skid register, which keeps
// full throughput while breaking the combinational path from m_ready to
// s_ready.
// -----------------------------------------------------------------------------
module case_convert_stream
   import case_pkg::*;
#(
   parameter int LANES   = 1,
   parameter int COUNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           mode,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [8*LANES-1:0]   s_data,
   input  logic                 s_last,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [8*LANES-1:0]   m_data,
   output logic                 m_last,
   output logic [COUNT_W-1:0]   m_count
);

   localparam int DATA_W = 8 * LANES;
   localparam int BEAT_W = $clog2(LANES + 1);
   // One spare bit above the wider operand so the sum can never wrap before
   // the saturation compare.
   localparam int SUM_W  = ((COUNT_W > BEAT_W) ? COUNT_W : BEAT_W) + 1;

   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   // ---------------------------------------------------------------------------
   // Framing state, mode latch and running count
   // ---------------------------------------------------------------------------
   state_t             state;
   logic [1:0]         cur_mode;
   logic [COUNT_W-1:0] run_count;

   logic               s_fire;
   logic [1:0]         eff_mode;

   assign s_fire = s_valid && s_ready;

   // The first beat of a message is converted with the mode presented
   // alongside it, not with the stale latched value.
   assign eff_mode = (state == ST_IDLE) ? mode : cur_mode;

   // ---------------------------------------------------------------------------
   // Per-lane conversion
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] conv_data;
   logic [LANES-1:0]  lane_changed;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      case_convert_lane u_lane (
         .char_in  (s_data[8*i +: 8]),
         .mode     (eff_mode),
         .char_out (conv_data[8*i +: 8]),
         .changed  (lane_changed[i])
      );
   end

   // ---------------------------------------------------------------------------
   // Popcount of changed lanes and saturating message total
   // ---------------------------------------------------------------------------
   logic [BEAT_W-1:0]  beat_changed;
   logic [SUM_W-1:0]   sum_ext;
   logic [COUNT_W-1:0] msg_total;
   logic [COUNT_W-1:0] beat_count;

   always_comb begin
      beat_changed = '0;
      for (int i = 0; i < LANES; i++) begin
         beat_changed = beat_changed + BEAT_W'(lane_changed[i]);
      end
   end

   always_comb begin
      sum_ext = SUM_W'(run_count) + SUM_W'(beat_changed);
      if (sum_ext > SUM_W'(COUNT_MAX)) begin
         msg_total = COUNT_MAX;
      end else begin
         msg_total = sum_ext[COUNT_W-1:0];
      end
      // Only the last beat of a message carries a count downstream.
      beat_count = s_last ? msg_total : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cur_mode  <= MODE_PASS;
         run_count <= '0;
      end else if (s_fire) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of block order.
         if (state == ST_IDLE) begin
            cur_mode <= mode;
         end
         state     <= s_last ? ST_IDLE : ST_IN_MSG;
         run_count <= s_last ? '0 : msg_total;
      end
   end

   // ---------------------------------------------------------------------------
   // Output register plus one-entry skid register
   // ---------------------------------------------------------------------------
   logic               skid_valid;
   logic [DATA_W-1:0]  skid_data;
   logic               skid_last;
   logic [COUNT_W-1:0] skid_count;

   logic out_free;
   logic skid_load;
   logic skid_drain;
   logic skid_valid_next;

   // The output register can take a new beat when it is empty or its current
   // beat is leaving this cycle.
   assign out_free = !m_valid || m_ready;

   always_comb begin
      // s_ready mirrors "skid empty", so an accepted beat always finds either
      // the output register or the skid free.
      skid_load       = s_fire && !out_free;
      skid_drain      = out_free && skid_valid;
      skid_valid_next = skid_valid;
      if (skid_load) begin
         skid_valid_next = 1'b1;
      end else if (skid_drain) begin
         skid_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data-path registers are reset as well so m_data and
         // m_count read 0 out of reset; these are flops, not a memory.
         s_ready    <= 1'b0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_last     <= 1'b0;
         m_count    <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_last  <= 1'b0;
         skid_count <= '0;
      end else begin
         s_ready    <= !skid_valid_next;
         skid_valid <= skid_valid_next;

         if (skid_load) begin
            skid_data  <= conv_data;
            skid_last  <= s_last;
            skid_count <= beat_count;
         end

         if (out_free) begin
            if (skid_valid) begin
               // An older parked beat always leaves before any new one.
               m_valid <= 1'b1;
               m_data  <= skid_data;
               m_last  <= skid_last;
               m_count <= skid_count;
            end else if (s_fire) begin
               m_valid <= 1'b1;
               m_data  <= conv_data;
               m_last  <= s_last;
               m_count <= beat_count;
            end else begin
               // m_data is left as-is; last/count drop so they cannot be
               // mistaken for a live final beat.
               m_valid <= 1'b0;
               m_last  <= 1'b0;
               m_count <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_case_convert_stream.sv
// -----------------------------------------------------------------------------
// tb_case_convert_stream
// Directed self-checking bench. Three instances share clk/rst_n:
//   a : LANES=1, COUNT_W=16 (single-lane message, mode hold, backpressure,
//       reset mid-message)
//   b : LANES=4, COUNT_W=16 (multi-lane conversion and pass-through bytes)
//   c : LANES=1, COUNT_W=2  (count saturation)
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_case_convert_stream;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // Instance a
   logic [1:0]  a_mode;
   logic        a_s_valid, a_s_ready, a_s_last;
   logic [7:0]  a_s_data;
   logic        a_m_valid, a_m_ready, a_m_last;
   logic [7:0]  a_m_data;
   logic [15:0] a_m_count;

   // Instance b
   logic [1:0]  b_mode;
   logic        b_s_valid, b_s_ready, b_s_last;
   logic [31:0] b_s_data;
   logic        b_m_valid, b_m_ready, b_m_last;
   logic [31:0] b_m_data;
   logic [15:0] b_m_count;

   // Instance c
   logic [1:0]  c_mode;
   logic        c_s_valid, c_s_ready, c_s_last;
   logic [7:0]  c_s_data;
   logic        c_m_valid, c_m_ready, c_m_last;
   logic [7:0]  c_m_data;
   logic [1:0]  c_m_count;

   case_convert_stream #(.LANES(1), .COUNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .mode(a_mode),
      .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_last(a_s_last),
      .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last),
      .m_count(a_m_count)
   );

   case_convert_stream #(.LANES(4), .COUNT_W(16)) u_b (
      .clk(clk), .rst_n(rst_n), .mode(b_mode),
      .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
      .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
      .m_count(b_m_count)
   );

   case_convert_stream #(.LANES(1), .COUNT_W(2)) u_c (
      .clk(clk), .rst_n(rst_n), .mode(c_mode),
      .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data), .s_last(c_s_last),
      .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data), .m_last(c_m_last),
      .m_count(c_m_count)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic a_beat(input logic [7:0] d, input logic last, input logic [1:0] md);
      @(negedge clk);
      a_s_valid = 1'b1; a_s_data = d; a_s_last = last; a_mode = md;
      @(posedge clk); #1;
   endtask

   task automatic b_beat(input logic [31:0] d, input logic last, input logic [1:0] md);
      @(negedge clk);
      b_s_valid = 1'b1; b_s_data = d; b_s_last = last; b_mode = md;
      @(posedge clk); #1;
   endtask

   task automatic c_beat(input logic [7:0] d, input logic last, input logic [1:0] md);
      @(negedge clk);
      c_s_valid = 1'b1; c_s_data = d; c_s_last = last; c_mode = md;
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Directed vectors
   logic [7:0]  hello_in  [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
   logic [7:0]  hello_exp [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

   logic [31:0] b_in   [12] = '{32'h7A314261,
                                32'h5B607B31, 32'h5B607B31, 32'h5B607B31, 32'h5B607B31,
                                32'h80FF4031, 32'h80FF4031, 32'h80FF4031, 32'h80FF4031,
                                32'h417A615A, 32'h417A615A, 32'h417A615A};
   logic [1:0]  b_md   [12] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                                2'd1, 2'd2, 2'd0};
   logic [31:0] b_exp  [12] = '{32'h5A316241,
                                32'h5B607B31, 32'h5B607B31, 32'h5B607B31, 32'h5B607B31,
                                32'h80FF4031, 32'h80FF4031, 32'h80FF4031, 32'h80FF4031,
                                32'h415A415A, 32'h617A617A, 32'h417A615A};
   logic [15:0] b_cnt  [12] = '{16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                                16'd0, 16'd2, 16'd2, 16'd0};
   logic [1:0]  c_cnt  [5]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3};

   logic [7:0] rx_data [$];
   logic       rx_last [$];
   logic       acc;
   int         idx;
   int         cyc;

   initial begin
      rst_n = 1'b0;
      a_mode = 2'd0; a_s_valid = 1'b0; a_s_data = '0; a_s_last = 1'b0; a_m_ready = 1'b1;
      b_mode = 2'd0; b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b1;
      c_mode = 2'd0; c_s_valid = 1'b0; c_s_data = '0; c_s_last = 1'b0; c_m_ready = 1'b1;

      // ---------------- reset state ----------------
      #2;
      check("rst_s_ready",  a_s_ready, 1'b0);
      check("rst_m_valid",  a_m_valid, 1'b0);
      check("rst_m_data",   a_m_data,  8'h00);
      check("rst_m_last",   a_m_last,  1'b0);
      check("rst_m_count",  a_m_count, 16'd0);
      check("rst_b_m_data", b_m_data,  32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_s_ready", a_s_ready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_a_s_ready", a_s_ready, 1'b1);
      check("rel_b_s_ready", b_s_ready, 1'b1);
      check("rel_c_s_ready", c_s_ready, 1'b1);

      // ---------------- "Hello" in UPPER ----------------
      for (int i = 0; i < 5; i++) begin
         a_beat(hello_in[i], (i == 4), 2'd1);
         check("hello_valid", a_m_valid, 1'b1);
         check("hello_data",  a_m_data,  hello_exp[i]);
         check("hello_last",  a_m_last,  (i == 4));
         check("hello_count", a_m_count, (i == 4) ? 16'd4 : 16'd0);
      end
      @(negedge clk); a_s_valid = 1'b0;
      @(posedge clk); #1;
      check("hello_idle_valid", a_m_valid, 1'b0);
      check("hello_idle_count", a_m_count, 16'd0);

      // ---------------- mode held for the message ----------------
      a_beat(8'h41, 1'b0, 2'd2);
      check("hold_b0_data", a_m_data, 8'h61);
      a_beat(8'h41, 1'b0, 2'd1);
      check("hold_b1_data", a_m_data, 8'h61);
      a_beat(8'h41, 1'b1, 2'd1);
      check("hold_b2_data",  a_m_data,  8'h61);
      check("hold_b2_count", a_m_count, 16'd3);
      check("hold_b2_last",  a_m_last,  1'b1);
      a_beat(8'h61, 1'b1, 2'd1);
      check("hold_next_data",  a_m_data,  8'h41);
      check("hold_next_count", a_m_count, 16'd1);
      @(negedge clk); a_s_valid = 1'b0;

      // ---------------- 4-lane conversion and pass-through ----------------
      for (int i = 0; i < 12; i++) begin
         b_beat(b_in[i], 1'b1, b_md[i]);
         check("lane4_valid", b_m_valid, 1'b1);
         check("lane4_data",  b_m_data,  b_exp[i]);
         check("lane4_count", b_m_count, b_cnt[i]);
      end
      @(negedge clk); b_s_valid = 1'b0;

      // ---------------- saturation, COUNT_W=2 ----------------
      for (int i = 0; i < 5; i++) begin
         c_beat(8'h61, (i == 4), 2'd1);
         check("sat_data",  c_m_data,  8'h41);
         check("sat_count", c_m_count, c_cnt[i]);
      end
      c_beat(8'h62, 1'b1, 2'd1);
      check("sat_next_data",  c_m_data,  8'h42);
      check("sat_next_count", c_m_count, 2'd1);
      @(negedge clk); c_s_valid = 1'b0;

      // ---------------- backpressure, 6 beats, stall 4 cycles ----------------
      idx = 0;
      cyc = 0;
      a_mode = 2'd0;
      while ((rx_data.size() < 6) && (cyc < 40)) begin
         @(negedge clk);
         a_m_ready = !((cyc >= 2) && (cyc <= 5));
         a_s_valid = (idx < 6);
         a_s_data  = 8'(idx + 1);
         a_s_last  = (idx == 5);
         #1;
         if (a_m_valid && a_m_ready) begin
            rx_data.push_back(a_m_data);
            rx_last.push_back(a_m_last);
         end
         acc = a_s_valid && a_s_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         if (cyc == 2) check("bp_ready_drop", a_s_ready, 1'b0);
         if ((cyc >= 2) && (cyc <= 5)) begin
            check("bp_hold_valid", a_m_valid, 1'b1);
            check("bp_hold_data",  a_m_data,  8'h02);
         end
         cyc++;
      end
      @(negedge clk); a_s_valid = 1'b0; a_m_ready = 1'b1;
      check("bp_rx_count", rx_data.size(), 6);
      for (int i = 0; i < rx_data.size(); i++) begin
         check("bp_rx_data", rx_data[i], 8'(i + 1));
         check("bp_rx_last", rx_last[i], (i == 5));
      end

      // ---------------- reset mid-message with the skid full ----------------
      @(negedge clk);
      a_m_ready = 1'b0;
      a_s_valid = 1'b1; a_s_data = 8'h61; a_s_last = 1'b0; a_mode = 2'd1;
      @(posedge clk); #1;
      check("mid_first_valid", a_m_valid, 1'b1);
      @(negedge clk);
      a_s_data = 8'h62;
      @(posedge clk); #1;
      check("mid_skid_full_ready", a_s_ready, 1'b0);
      @(negedge clk);
      a_s_data = 8'h63;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_m_valid", a_m_valid, 1'b0);
      check("mid_rst_s_ready", a_s_ready, 1'b0);
      check("mid_rst_m_count", a_m_count, 16'd0);
      a_s_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      a_m_ready = 1'b1;
      @(posedge clk); #1;
      check("mid_rel_s_ready", a_s_ready, 1'b1);
      check("mid_rel_m_valid", a_m_valid, 1'b0);
      a_beat(8'h61, 1'b1, 2'd0);
      check("mid_fresh_data",  a_m_data,  8'h61);
      check("mid_fresh_last",  a_m_last,  1'b1);
      check("mid_fresh_count", a_m_count, 16'd0);
      @(negedge clk); a_s_valid = 1'b0;
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/case_convert_stream.md
# case_convert_stream

Streaming ASCII case converter, the parametrised successor to the 8-bit combinational toupper block. It accepts LANES bytes per beat on a valid/ready stream framed by a last flag. Each message is converted in one of four modes, latched when the message starts. The block emits the converted beats with one cycle of latency and a per-message count of changed characters. It sits between a byte-stream source (UART/FIFO) and downstream text consumers.

## Interface
- LANES, 1, bytes per beat (1..16); byte i occupies bits [8i+7:8i], lane 0 = first character.
- COUNT_W, 16, width of the changed-character counter (saturating).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mode  in  2  0=PASS, 1=UPPER, 2=LOWER, 3=TOGGLE; sampled only on the first beat of a message.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  8*LANES  input characters.
- s_last  in  1  final beat of message.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  8*LANES  converted characters.
- m_last  out  1  final beat of message.
- m_count  out  COUNT_W  changed-character total for the message; valid only when m_valid && m_last, else 0.

## Operation
- Letter classes:
  - lower = 0x61..0x7A; upper = 0x41..0x5A.
  - Conversion inverts bit 5.
  - All other bytes, including 0x80..0xFF, pass unchanged.
- Per-byte rule:
  - UPPER converts lower letters only.
  - LOWER converts upper letters only.
  - TOGGLE converts both classes.
  - PASS converts nothing.
- FSM:
  - IDLE: accepting a beat latches `mode` into `cur_mode` and converts that beat with the new mode. If s_last=0, go to IN_MSG; otherwise stay in IDLE.
  - IN_MSG: beats use `cur_mode`, and `mode` is ignored. Accepting s_last=1 returns to IDLE.
- Counting:
  - The per-beat changed count (0..LANES) is added to the running message count.
  - The sum saturates at 2^COUNT_W-1.
  - When the last beat is accepted, the final total travels with that beat to m_count. The running count clears to 0 in the same cycle.
- A single-beat message (s_last on its first beat) is legal; its count is that beat's changed count.

## Timing
- Reset values:
  - s_ready=0, m_valid=0, m_data=0, m_last=0, m_count=0.
  - FSM=IDLE, cur_mode=PASS, running count=0.
  - s_ready rises at the first clk edge after rst_n deasserts.
- Latency: an accepted beat appears on m_* at the next rising edge (1 cycle).
- Buffering: output register plus a one-entry skid register.
  - s_ready is registered and equals "skid empty".
  - A full-throughput stream with m_ready=1 runs 1 beat/cycle with no bubbles.
- Backpressure:
  - While m_valid && !m_ready, m_data, m_last and m_count hold stable.
  - A beat accepted while the output register is stalled goes to the skid register, and s_ready drops the next cycle.
  - When m_ready returns, the skid register drains into the output register first. s_ready rises one cycle after the skid register empties.
  - No beat is lost or duplicated.
- Simultaneous accept and drain in the same cycle is legal; the output register reloads with no bubble.
- Reset mid-message: all beats in flight (output and skid registers) are discarded, the partial count is discarded, and the FSM returns to IDLE. The next accepted beat starts a new message.
- m_valid never depends combinationally on m_ready; s_ready never depends combinationally on s_valid.

## Structure
- Package case_pkg holds:
  - the mode enum (MODE_PASS, MODE_UPPER, MODE_LOWER, MODE_TOGGLE);
  - the ASCII bound constants (0x41, 0x5A, 0x61, 0x7A);
  - the case-bit constant (bit 5);
  - the FSM state typedef.
- Sub-module case_convert_lane: purely combinational, one byte plus mode in, converted byte plus changed flag out. It is instantiated LANES times via generate.
- The top level contains:
  - the FSM and mode latch;
  - the running counter with saturation;
  - a popcount adder tree over the changed flags;
  - the output/skid registers.

## Test plan
- LANES=1, mode=UPPER, message 0x48,0x65,0x6C,0x6C,0x6F ("Hello") with m_ready=1 → outputs 0x48,0x45,0x4C,0x4C,0x4F one cycle after each input; m_last on the fifth beat; m_count=4.
- LANES=4, mode=TOGGLE, single beat s_data=0x7A314261 with s_last=1 → m_data=0x5A316241, m_count=3; bytes 0x31, 0x80, 0xFF, 0x40, 0x5B, 0x60 and 0x7B pass unchanged in every mode.
- Mode held for the message: start with mode=LOWER, change mode to UPPER on beat 2 of a 3-beat message of 0x41 bytes → all outputs 0x61, m_count=3. The next message starts with UPPER applied.
- Backpressure: 6-beat stream, m_ready low for 4 cycles mid-stream → s_ready drops after the skid fills, m_data is stable while stalled, all 6 beats arrive in order with no duplicates.
- Saturation: COUNT_W=2, LANES=1, UPPER, 5 lowercase beats → m_count=3 on the last beat. The next message's count starts from 0.
- Reset mid-operation: assert rst_n=0 during beat 2 of 4 with the skid full → m_valid=0 immediately and s_ready=0. After release, s_ready=1 one edge later, and a fresh 1-beat PASS message yields m_count=0.
